// File: rtl/vend_if.sv
// Bundle between the vending front end / dispensers and vend_controller.
// master drives the coin, keypad, restock and ack strobes; slave is the controller.
interface vend_if;
  logic       coin_valid;
  logic [3:0] coin_val;
  logic       buy;
  logic [1:0] sel;
  logic       cancel;
  logic       restock;
  logic [1:0] restock_sel;
  logic [3:0] restock_qty;
  logic       vend_ack;
  logic       chg_ack;
  logic [4:0] credit;
  logic       yes;
  logic       no;
  logic       coin_rej;
  logic       timeout;
  logic       vend_req;
  logic [1:0] vend_sel;
  logic       chg_req;
  logic [3:0] empty;
  logic       busy;

  modport master (
    output coin_valid, coin_val, buy, sel, cancel, restock, restock_sel, restock_qty,
           vend_ack, chg_ack,
    input  credit, yes, no, coin_rej, timeout, vend_req, vend_sel, chg_req, empty, busy
  );

  modport slave (
    input  coin_valid, coin_val, buy, sel, cancel, restock, restock_sel, restock_qty,
           vend_ack, chg_ack,
    output credit, yes, no, coin_rej, timeout, vend_req, vend_sel, chg_req, empty, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, purchase check, stock, vend and change handshakes.
// Optional idle auto-refund in COLLECT is built when AUTO_REFUND_EN is defined.
module vend_controller #(
  parameter logic [3:0]  STOCK_INIT = 4'd5,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input  logic   clk,
  input  logic   rst,
  vend_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic [3:0] stock_q [4];
  logic [3:0] stock_d [4];
  logic [1:0] vend_sel_q, vend_sel_d;
  logic       yes_q, yes_d;
  logic       no_q, no_d;
  logic       coin_rej_q, coin_rej_d;
  logic       vend_req_q, chg_req_q;
  logic [5:0] coin_sum;
  logic       coin_fits;
  logic [4:0] fare;
  logic       buy_ok;

  function automatic logic [4:0] fare_of(input logic [1:0] s);
    case (s)
      2'd0:    return 5'd5;
      2'd1:    return 5'd8;
      2'd2:    return 5'd10;
      default: return 5'd12;
    endcase
  endfunction

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  assign coin_sum  = {1'b0, credit_q} + {2'b00, bus.coin_val};
  assign coin_fits = !coin_sum[5];
  assign fare      = fare_of(bus.sel);
  assign buy_ok    = (credit_q >= fare) && (stock_q[bus.sel] != 4'd0);

`ifdef AUTO_REFUND_EN
  logic        collect_idle;
  logic        to_fire;
  logic [15:0] to_cnt_q;
  logic        timeout_q;

  // An idle COLLECT cycle is one with no cancel, no buy attempt and no accepted coin.
  assign collect_idle = (state_q == COLLECT) && !bus.cancel && !bus.buy &&
                        !(bus.coin_valid && coin_fits);
  assign to_fire      = collect_idle && (to_cnt_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (collect_idle && !to_fire) to_cnt_q <= to_cnt_q + 16'd1;
      else                          to_cnt_q <= '0;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    stock_d    = stock_q;
    vend_sel_d = vend_sel_q;
    yes_d      = 1'b0;
    no_d       = 1'b0;
    coin_rej_d = 1'b0;
    case (state_q)
      IDLE: begin
        no_d = bus.buy;
        if (bus.coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[4:0];
            if (bus.coin_val != 4'd0) state_d = COLLECT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
        if (bus.restock)
          stock_d[bus.restock_sel] = sat_add4(stock_q[bus.restock_sel], bus.restock_qty);
      end
      COLLECT: begin
        // cancel beats buy beats coin; a coin losing arbitration is rejected
        coin_rej_d = bus.coin_valid && (bus.cancel || bus.buy || !coin_fits);
        if (bus.cancel) begin
          state_d = (credit_q != 5'd0) ? CHANGE : IDLE;
        end else if (bus.buy) begin
          if (buy_ok) begin
            credit_d          = credit_q - fare;
            stock_d[bus.sel]  = stock_q[bus.sel] - 4'd1;
            vend_sel_d        = bus.sel;
            yes_d             = 1'b1;
            state_d           = VEND;
          end else begin
            no_d = 1'b1;
          end
        end else if (bus.coin_valid && coin_fits) begin
          credit_d = coin_sum[4:0];
        end
`ifdef AUTO_REFUND_EN
        else if (to_fire) begin
          state_d = (credit_q != 5'd0) ? CHANGE : IDLE;
        end
`endif
      end
      VEND: begin
        coin_rej_d = bus.coin_valid;
        if (bus.vend_ack && vend_req_q)
          state_d = (credit_q != 5'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_rej_d = bus.coin_valid;
        if (credit_q == 5'd0) begin
          state_d = IDLE;
        end else if (bus.chg_ack && chg_req_q) begin
          credit_d = credit_q - 5'd1;
          if (credit_q == 5'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      vend_sel_q <= '0;
      yes_q      <= 1'b0;
      no_q       <= 1'b0;
      coin_rej_q <= 1'b0;
      vend_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_INIT;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_sel_q <= vend_sel_d;
      yes_q      <= yes_d;
      no_q       <= no_d;
      coin_rej_q <= coin_rej_d;
      vend_req_q <= (state_d == VEND);
      chg_req_q  <= (state_d == CHANGE);
      stock_q    <= stock_d;
    end
  end

  assign bus.credit   = credit_q;
  assign bus.yes      = yes_q;
  assign bus.no       = no_q;
  assign bus.coin_rej = coin_rej_q;
  assign bus.vend_req = vend_req_q;
  assign bus.vend_sel = vend_sel_q;
  assign bus.chg_req  = chg_req_q;
  assign bus.empty    = {stock_q[3] == 4'd0, stock_q[2] == 4'd0,
                         stock_q[1] == 4'd0, stock_q[0] == 4'd0};
  assign bus.busy     = (state_q == VEND) || (state_q == CHANGE);

endmodule
